sd_sector_server: RTL and testbench
===================================

Name: sd_sector_server

Overview:
- Responder side of the sector-buffer handshake used by the drive track loaders (sd_rd/sd_wr/sd_ack/sd_buff_*).
- Serves 512-byte sector reads and writes from a byte-wide disk-image memory (SDRAM RAM-disk port) instead of the IO controller.
- Lets a drive core run from a preloaded image without ARM/SPI traffic; also serves as the bench model for the track loaders.

Parameters:
- LBA_BITS, 15, width of the sector address held against the image; mem_addr width is LBA_BITS+9.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- img_mounted  in  1  image present in memory.
- img_size  in  LBA_BITS+1  image length in 512-byte sectors.
- sd_lba  in  32  sector number from initiator.
- sd_rd  in  1  read request (level, held until sd_ack seen).
- sd_wr  in  1  write request (level, held until sd_ack seen).
- sd_ack  out  1  transfer in progress.
- sd_buff_addr  out  9  byte index within sector.
- sd_buff_dout  out  8  read data to initiator buffer.
- sd_buff_din  in  8  write data from initiator buffer; valid 1 clk after sd_buff_addr.
- sd_buff_wr  out  1  one-cycle strobe: sd_buff_dout valid at sd_buff_addr.
- mem_addr  out  LBA_BITS+9  byte address {lba[LBA_BITS-1:0], byte[8:0]}.
- mem_rd  out  1  memory read request.
- mem_wr  out  1  memory write request.
- mem_din  out  8  write data to memory.
- mem_dout  in  8  read data from memory; valid in the accept cycle.
- mem_ready  in  1  accept; a request completes in any cycle with (mem_rd|mem_wr)&mem_ready.
- err  out  1  sticky: out-of-range or unmounted access occurred.

Behaviour:
- Reset: all outputs 0, FSM to IDLE; takes effect mid-transfer. sd_ack and mem_rd/mem_wr drop the next cycle and the request is abandoned. err cleared only by reset.
- States: IDLE, RD_REQ, RD_PUT, WR_ADDR, WR_SAMPLE, WR_REQ, DONE.
- IDLE, entered on a cycle with sd_rd or sd_wr high:
  - latch lba = sd_lba; byte counter = 0; sd_ack <= 1.
  - sd_rd and sd_wr both high: read served, write ignored (initiator drops both on ack).
  - valid = img_mounted && sd_lba < img_size (32-bit compare, img_size zero-extended). If !valid, set err.
- Read, per byte i = 0..511:
  - RD_REQ: if valid, assert mem_rd with mem_addr = {lba, i} and hold until mem_ready; capture mem_dout. If !valid, no memory access; data = 8'h00; one cycle.
  - RD_PUT: sd_buff_addr = i, sd_buff_dout = data, sd_buff_wr = 1 for exactly one cycle.
  - After i = 511 go to DONE, otherwise i+1 and back to RD_REQ.
  - sd_buff_wr never asserts while sd_ack = 0.
- Write, per byte i:
  - WR_ADDR: drive sd_buff_addr = i.
  - WR_SAMPLE: one cycle later, sample sd_buff_din; sd_buff_addr is held stable for both cycles.
  - WR_REQ: if valid, assert mem_wr, mem_addr = {lba, i}, mem_din = sample, held until mem_ready. If !valid, the byte is discarded in one cycle.
  - After 511 go to DONE.
- DONE: sd_ack <= 0; return to IDLE. sd_ack stays low ≥1 cycle. A request seen in IDLE on the cycle after DONE starts a new transfer; back-to-back multi-sector sequences need no gaps beyond this.
- mem_rd/mem_wr deassert in the cycle after acceptance. Never both high.
- Request level is ignored while sd_ack = 1.
- Byte counter is 10 bits; terminal at 511, no wrap into the next sector.
- lba bits above LBA_BITS affect only the range check, never mem_addr.
- Zero-wait-state memory (mem_ready tied 1): read sector = 1 + 512*2 + 1 cycles ack-to-ack edge; write = 512*3 + 2.

Test Plan:
- Memory byte k = k[7:0]^lba[7:0], mem_ready = 1, sd_rd with sd_lba = 3:
  - sd_ack rises 1 clk after request.
  - 512 sd_buff_wr strobes, addr 0..511, data addr^8'h03.
  - mem_addr runs 0x600..0x7FF.
  - sd_ack falls; err = 0.
- Initiator model re-asserts sd_rd on each ack falling edge for lba 10..13:
  - four complete sectors, no lost or duplicated strobe, correct lba per sector.
- sd_wr lba 5, initiator buffer byte j = ~j[7:0], registered 1-clk read, mem_ready random 0–3 wait cycles:
  - memory bytes 0xA00..0xBFF = ~j; mem_wr count = 512.
- img_size = 4, sd_rd lba 4:
  - 512 strobes of 8'h00; zero mem_rd; err = 1.
  - Then sd_wr lba 7: zero mem_wr; err stays 1.
- reset pulsed at byte 200 of a read with mem_rd pending:
  - next cycle sd_ack = 0, mem_rd = 0, sd_buff_wr = 0, err = 0.
  - A following sd_rd lba 0 completes correctly.
- sd_rd and sd_wr asserted together, lba 1:
  - read transfer only; no mem_wr.

Source files
------------

// File: rtl/sd_sector_server.sv
// Sector-buffer responder: serves 512-byte sector reads/writes from a byte-wide image memory.
module sd_sector_server #(
    parameter int unsigned LBA_BITS = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  img_mounted,
    input  logic [LBA_BITS:0]     img_size,
    input  logic [31:0]           sd_lba,
    input  logic                  sd_rd,
    input  logic                  sd_wr,
    output logic                  sd_ack,
    output logic [8:0]            sd_buff_addr,
    output logic [7:0]            sd_buff_dout,
    input  logic [7:0]            sd_buff_din,
    output logic                  sd_buff_wr,
    output logic [LBA_BITS+8:0]   mem_addr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [7:0]            mem_din,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_ready,
    output logic                  err
);

    localparam int unsigned BYTE_W = 9;
    localparam int unsigned CNT_W  = 10;
    localparam int unsigned ADDR_W = LBA_BITS + BYTE_W;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(511);

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_PUT,
        WR_ADDR,
        WR_SAMPLE,
        WR_REQ,
        DONE
    } state_t;

    state_t              state, state_nx;
    logic [LBA_BITS-1:0] lba, lba_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx, cnt_inc;
    logic                valid, valid_nx;
    logic                ack_nx, buff_wr_nx, rd_nx, wr_nx, err_nx;
    logic [BYTE_W-1:0]   buff_addr_nx;
    logic [7:0]          buff_dout_nx, din_nx;
    logic [ADDR_W-1:0]   addr_nx;
    logic                lba_ok_c, accept_c;

    // Range check against the mounted image, done on the full 32-bit sector number
    assign lba_ok_c = img_mounted && (sd_lba < 32'(img_size));
    assign accept_c = (mem_rd | mem_wr) & mem_ready;
    assign cnt_inc  = cnt + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        lba_nx       = lba;
        cnt_nx       = cnt;
        valid_nx     = valid;
        ack_nx       = sd_ack;
        buff_addr_nx = sd_buff_addr;
        buff_dout_nx = sd_buff_dout;
        buff_wr_nx   = 1'b0;
        addr_nx      = mem_addr;
        rd_nx        = mem_rd;
        wr_nx        = mem_wr;
        din_nx       = mem_din;
        err_nx       = err;
        case (state)
            IDLE: begin
                if (sd_rd || sd_wr) begin
                    lba_nx       = sd_lba[LBA_BITS-1:0];
                    cnt_nx       = '0;
                    ack_nx       = 1'b1;
                    valid_nx     = lba_ok_c;
                    buff_addr_nx = '0;
                    addr_nx      = {sd_lba[LBA_BITS-1:0], BYTE_W'(0)};
                    if (!lba_ok_c) begin
                        err_nx = 1'b1;
                    end
                    // A read wins when both requests are raised together
                    if (sd_rd) begin
                        rd_nx    = lba_ok_c;
                        state_nx = RD_REQ;
                    end else begin
                        state_nx = WR_ADDR;
                    end
                end
            end
            RD_REQ: begin
                if (!valid || accept_c) begin
                    rd_nx        = 1'b0;
                    buff_wr_nx   = 1'b1;
                    buff_addr_nx = cnt[BYTE_W-1:0];
                    buff_dout_nx = valid ? mem_dout : 8'h00;
                    state_nx     = RD_PUT;
                end
            end
            RD_PUT: begin
                if (cnt == LAST_BYTE) begin
                    state_nx = DONE;
                end else begin
                    cnt_nx   = cnt_inc;
                    rd_nx    = valid;
                    addr_nx  = {lba, cnt_inc[BYTE_W-1:0]};
                    state_nx = RD_REQ;
                end
            end
            WR_ADDR: begin
                state_nx = WR_SAMPLE;
            end
            WR_SAMPLE: begin
                din_nx   = sd_buff_din;
                addr_nx  = {lba, cnt[BYTE_W-1:0]};
                wr_nx    = valid;
                state_nx = WR_REQ;
            end
            WR_REQ: begin
                if (!valid || accept_c) begin
                    wr_nx = 1'b0;
                    if (cnt == LAST_BYTE) begin
                        state_nx = DONE;
                    end else begin
                        cnt_nx       = cnt_inc;
                        buff_addr_nx = cnt_inc[BYTE_W-1:0];
                        state_nx     = WR_ADDR;
                    end
                end
            end
            DONE: begin
                ack_nx   = 1'b0;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset abandons any transfer in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lba          <= '0;
            cnt          <= '0;
            valid        <= 1'b0;
            sd_ack       <= 1'b0;
            sd_buff_addr <= '0;
            sd_buff_dout <= '0;
            sd_buff_wr   <= 1'b0;
            mem_addr     <= '0;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_din      <= '0;
            err          <= 1'b0;
        end else begin
            state        <= state_nx;
            lba          <= lba_nx;
            cnt          <= cnt_nx;
            valid        <= valid_nx;
            sd_ack       <= ack_nx;
            sd_buff_addr <= buff_addr_nx;
            sd_buff_dout <= buff_dout_nx;
            sd_buff_wr   <= buff_wr_nx;
            mem_addr     <= addr_nx;
            mem_rd       <= rd_nx;
            mem_wr       <= wr_nx;
            mem_din      <= din_nx;
            err          <= err_nx;
        end
    end

endmodule

// File: tb/tb_sd_sector_server.sv
// Bench for sd_sector_server: initiator + image memory model, sector-level expectations.
module tb_sd_sector_server;

    localparam int unsigned LBA_BITS = 15;
    localparam int unsigned AW       = LBA_BITS + 9;

    logic              clk          = 1'b0;
    logic              reset        = 1'b1;
    logic              img_mounted  = 1'b0;
    logic [LBA_BITS:0] img_size     = '0;
    logic [31:0]       sd_lba       = '0;
    logic              sd_rd        = 1'b0;
    logic              sd_wr        = 1'b0;
    logic              sd_ack;
    logic [8:0]        sd_buff_addr;
    logic [7:0]        sd_buff_dout;
    logic [7:0]        sd_buff_din  = '0;
    logic              sd_buff_wr;
    logic [AW-1:0]     mem_addr;
    logic              mem_rd;
    logic              mem_wr;
    logic [7:0]        mem_din;
    logic [7:0]        mem_dout     = '0;
    logic              mem_ready    = 1'b1;
    logic              err;

    always #5 clk = ~clk;

    sd_sector_server #(.LBA_BITS(LBA_BITS)) dut (
        .clk(clk), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din),
        .sd_buff_wr(sd_buff_wr), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_ready(mem_ready), .err(err)
    );

    int            n_checks   = 0;
    int            n_pass     = 0;
    logic [7:0]    mem_w [int unsigned];
    logic [16:0]   exp_strobe_q [$];
    logic [AW-1:0] exp_addr_q [$];
    int            strobe_cnt = 0;
    int            rd_cnt     = 0;
    int            wr_cnt     = 0;
    logic [16:0]   last_strobe = '0;
    logic [AW-1:0] first_addr  = '0;
    logic [AW-1:0] last_addr   = '0;
    bit            first_seen  = 1'b0;
    bit            rand_wait   = 1'b0;
    bit            stall       = 1'b0;
    bit            err_exp     = 1'b0;
    int            wait_left   = -1;
    logic [7:0]    wkey        = '0;
    logic [8:0]    prev_buff_addr = '0;

    // Image contents: written bytes, otherwise byte k of sector lba = k ^ lba
    function automatic logic [7:0] mem_read(input logic [AW-1:0] a);
        if (mem_w.exists(32'(a))) return mem_w[32'(a)];
        return a[7:0] ^ a[16:9];
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Memory responder, initiator buffer and per-cycle output compare
    always @(negedge clk) begin
        if (stall) begin
            mem_ready = 1'b0;
            wait_left = -1;
        end else if (rand_wait && (mem_rd || mem_wr)) begin
            if (wait_left < 0) wait_left = int'($urandom_range(0, 3));
            mem_ready = (wait_left == 0);
            wait_left--;
        end else begin
            mem_ready = 1'b1;
            wait_left = -1;
        end
        mem_dout       = mem_read(mem_addr);
        sd_buff_din    = ~prev_buff_addr[7:0] ^ wkey;
        prev_buff_addr = sd_buff_addr;
        if (!reset) begin
            if (mem_rd || mem_wr) check("rd_wr_exclusive", 64'(mem_rd & mem_wr), 0);
            if ((mem_rd || mem_wr) && mem_ready) begin
                if (mem_rd) rd_cnt++;
                if (mem_wr) begin
                    wr_cnt++;
                    mem_w[32'(mem_addr)] = mem_din;
                end
                if (!first_seen) first_addr = mem_addr;
                first_seen = 1'b1;
                last_addr  = mem_addr;
                check("mem_access_expected", 64'(exp_addr_q.size() > 0), 1);
                if (exp_addr_q.size() > 0) check("mem_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
            end
            if (sd_buff_wr) begin
                strobe_cnt++;
                last_strobe = {sd_buff_addr, sd_buff_dout};
                check("strobe_under_ack", 64'(sd_ack), 1);
                check("strobe_expected", 64'(exp_strobe_q.size() > 0), 1);
                if (exp_strobe_q.size() > 0)
                    check("strobe_addr_data", 64'({sd_buff_addr, sd_buff_dout}), 64'(exp_strobe_q.pop_front()));
            end
        end
    end

    // One sector transfer from the initiator side; caller is at a negedge
    task automatic do_xfer(input bit rd, input bit wr, input logic [31:0] lba,
                           input bit rwait, input logic [7:0] key);
        bit            valid;
        int            cyc, rd0, wr0, st0, bad;
        logic [AW-1:0] a;
        valid = img_mounted && (lba < 32'(img_size));
        if (!valid) err_exp = 1'b1;
        rand_wait = rwait;
        wkey      = key;
        for (int i = 0; i < 512; i++) begin
            a = {lba[LBA_BITS-1:0], 9'(i)};
            if (rd) exp_strobe_q.push_back({9'(i), valid ? mem_read(a) : 8'h00});
            if (valid) exp_addr_q.push_back(a);
        end
        rd0 = rd_cnt; wr0 = wr_cnt; st0 = strobe_cnt;
        sd_lba = lba; sd_rd = rd; sd_wr = wr;
        @(negedge clk);
        check("ack_rise_1clk", 64'(sd_ack), 1);
        sd_rd = 1'b0; sd_wr = 1'b0;
        cyc = 1;
        while (sd_ack && cyc < 8000) begin
            @(negedge clk);
            cyc++;
        end
        if (!rwait) check("xfer_cycles", cyc, rd ? 1026 : 1538);
        else        check("ack_fall", 64'(sd_ack), 0);
        check("strobe_count", strobe_cnt - st0, rd ? 512 : 0);
        check("mem_rd_count", rd_cnt - rd0, (rd && valid) ? 512 : 0);
        check("mem_wr_count", wr_cnt - wr0, (!rd && wr && valid) ? 512 : 0);
        check("queues_drained", exp_strobe_q.size() + exp_addr_q.size(), 0);
        check("err", 64'(err), 64'(err_exp));
        if (wr && !rd && valid) begin
            bad = 0;
            for (int j = 0; j < 512; j++) begin
                a = {lba[LBA_BITS-1:0], 9'(j)};
                if (mem_read(a) != (~8'(j) ^ key)) bad++;
            end
            check("sector_contents", bad, 0);
        end
    endtask

    initial begin
        int          cyc, st0, op;
        logic [31:0] rl;
        repeat (3) @(negedge clk);
        check("reset_ack", 64'(sd_ack), 0);
        check("reset_mem_rd", 64'(mem_rd), 0);
        check("reset_mem_wr", 64'(mem_wr), 0);
        check("reset_buff_wr", 64'(sd_buff_wr), 0);
        check("reset_err", 64'(err), 0);
        reset = 1'b0; img_mounted = 1'b1; img_size = 16'd1024;
        @(negedge clk);

        // Single read of sector 3, zero-wait memory
        first_seen = 1'b0;
        do_xfer(1'b1, 1'b0, 32'd3, 1'b0, 8'h00);
        check("rd3_first_addr", 64'(first_addr), 64'h600);
        check("rd3_last_addr", 64'(last_addr), 64'h7FF);
        check("rd3_last_strobe", 64'(last_strobe), 64'h1FFFC);

        // Back-to-back sectors 10..13, request re-raised as ack falls
        for (int k = 0; k < 4; k++) do_xfer(1'b1, 1'b0, 32'(10 + k), 1'b0, 8'h00);

        // Write sector 5 with random wait states, then read it back
        do_xfer(1'b0, 1'b1, 32'd5, 1'b1, 8'h00);
        check("wr5_byte0", 64'(mem_read(24'hA00)), 64'hFF);
        check("wr5_byte511", 64'(mem_read(24'hBFF)), 64'h00);
        do_xfer(1'b1, 1'b0, 32'd5, 1'b1, 8'h00);

        // Out-of-range read then write
        img_size = 16'd4;
        do_xfer(1'b1, 1'b0, 32'd4, 1'b0, 8'h00);
        check("oor_last_strobe", 64'(last_strobe), 64'h1FF00);
        check("oor_err_set", 64'(err), 1);
        do_xfer(1'b0, 1'b1, 32'd7, 1'b0, 8'h5A);

        // Reset in the middle of a read with mem_rd held off
        img_size = 16'd1024;
        for (int i = 0; i < 512; i++) begin
            exp_strobe_q.push_back({9'(i), mem_read({15'd2, 9'(i)})});
            exp_addr_q.push_back({15'd2, 9'(i)});
        end
        st0 = strobe_cnt;
        sd_lba = 32'd2; sd_rd = 1'b1;
        @(negedge clk);
        sd_rd = 1'b0;
        cyc = 0;
        while ((strobe_cnt - st0) < 200 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_byte200", 64'((strobe_cnt - st0) >= 200), 1);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        cyc = 0;
        while (!mem_rd && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_mem_rd_pending", 64'(mem_rd), 1);
        check("abort_ack_high", 64'(sd_ack), 1);
        reset = 1'b1;
        exp_strobe_q.delete();
        exp_addr_q.delete();
        err_exp = 1'b0;
        @(negedge clk);
        check("abort_ack", 64'(sd_ack), 0);
        check("abort_mem_rd", 64'(mem_rd), 0);
        check("abort_buff_wr", 64'(sd_buff_wr), 0);
        check("abort_err", 64'(err), 0);
        reset = 1'b0; stall = 1'b0;
        repeat (2) @(negedge clk);
        do_xfer(1'b1, 1'b0, 32'd0, 1'b0, 8'h00);

        // Read and write raised together
        do_xfer(1'b1, 1'b1, 32'd1, 1'b0, 8'h00);

        // Randomised mix of reads/writes, mounts, ranges and wait states
        img_size = 16'd12;
        for (int t = 0; t < 6; t++) begin
            op          = int'($urandom_range(0, 2));
            rl          = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) rl = rl | 32'h0001_0000;
            img_mounted = ($urandom_range(0, 4) != 0);
            do_xfer(op != 1, op != 0, rl, 1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
